// File: rtl/bin_clock_ctrl.sv
// bin_clock_ctrl - timekeeping core of the binary clock.
//
// Divides clk down to a 1 Hz tick and keeps hours/minutes/seconds. Two
// debounced buttons drive a set-mode state machine: btn_mode cycles
// RUN -> SET_H -> SET_M -> SET_S -> RUN, and btn_inc bumps the field being
// edited. A registered, multiplexed 8-bit word feeds the display pins.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ena                 count enable (freezes the prescaler only)
//   btn_mode, btn_inc   raw asynchronous active-high buttons
//   disp_sel            display field select (sec / min / hr / status)
//   sec, min, hr        current time fields
//   mode                0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//   tick                one-cycle pulse in the cycle the time updates
//   blink               field-blink flag, toggles while editing
//   disp                registered display word
`timescale 1ns/1ps

module bin_clock_ctrl #(
  parameter int DIV       = 10000000,
  parameter int DB_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] disp_sel,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic [1:0] mode,
  output logic       tick,
  output logic       blink,
  output logic [7:0] disp
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] BLINK_LAST = PW'(DIV / 2 - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_e;

  // Button path; bit 0 is btn_mode, bit 1 is btn_inc.
  logic [1:0]         btn_sync1_q, btn_sync1_d;
  logic [1:0]         btn_sync2_q, btn_sync2_d;
  logic [1:0]         btn_acc_q, btn_acc_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         press;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          tick_q, tick_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [7:0]    disp_q, disp_d;

  logic mode_press;
  logic inc_press;

  // A level change is accepted only after DB_CYCLES consecutive differing
  // samples; the press event fires in the cycle a 0->1 change is accepted.
  always_comb begin
    btn_sync1_d = {btn_inc, btn_mode};
    btn_sync2_d = btn_sync1_q;
    btn_acc_d   = btn_acc_q;
    db_cnt_d    = db_cnt_q;
    press       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (btn_sync2_q[i] != btn_acc_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          btn_acc_d[i] = btn_sync2_q[i];
          db_cnt_d[i]  = '0;
          press[i]     = btn_sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // A mode press in the same cycle as an inc press wins; the inc is dropped.
  assign mode_press = press[0];
  assign inc_press  = press[1] & ~press[0];

  // Mode FSM, prescaler, time counters and blink generator.
  always_comb begin
    mode_d      = mode_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    tick_d      = 1'b0;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;

    if (mode_press) begin
      case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M:   mode_d = SET_S;
        default: mode_d = RUN;
      endcase
      // Every mode change restarts both dividers, so a return to RUN gets a
      // full second before its first tick and a new SET field starts lit.
      presc_d     = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (mode_q == RUN) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
      if (ena) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d = '0;
              hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end else begin
      presc_d = '0;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + PW'(1);
      end
      // Editing wraps the selected field only; no carry into its neighbour.
      if (inc_press) begin
        case (mode_q)
          SET_H:   hr_d  = (hr_q == 5'd23)  ? 5'd0 : hr_q + 5'd1;
          SET_M:   min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          default: sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        endcase
      end
    end
  end

  // Display word is built from the registered fields, one cycle behind them.
  always_comb begin
    disp_d = '0;
    case (disp_sel)
      2'd0:    disp_d = {2'b00, sec_q};
      2'd1:    disp_d = {2'b00, min_q};
      2'd2:    disp_d = {3'b000, hr_q};
      default: disp_d = {mode_q, blink_q, tick_q, 4'b0000};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      btn_acc_q   <= '0;
      db_cnt_q    <= '0;
      mode_q      <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      tick_q      <= 1'b0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      disp_q      <= '0;
    end else begin
      btn_sync1_q <= btn_sync1_d;
      btn_sync2_q <= btn_sync2_d;
      btn_acc_q   <= btn_acc_d;
      db_cnt_q    <= db_cnt_d;
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      tick_q      <= tick_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      disp_q      <= disp_d;
    end
  end

  assign sec   = sec_q;
  assign min   = min_q;
  assign hr    = hr_q;
  assign mode  = mode_q;
  assign tick  = tick_q;
  assign blink = blink_q;
  assign disp  = disp_q;

endmodule

// File: tb/tb_bin_clock_ctrl.sv
// tb_bin_clock_ctrl - self-checking bench for bin_clock_ctrl with a short
// second (DIV=4) and a short debounce (DB_CYCLES=2). Expected field values
// and expected tick arrivals are queued when stimulus is driven and are
// compared once the DUT is due to have produced them.
`timescale 1ns/1ps

module tb_bin_clock_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 2;

  localparam int SIG_SEC   = 0;
  localparam int SIG_MIN   = 1;
  localparam int SIG_HR    = 2;
  localparam int SIG_MODE  = 3;
  localparam int SIG_TICK  = 4;
  localparam int SIG_BLINK = 5;
  localparam int SIG_DISP  = 6;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ena      = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc  = 1'b0;
  logic [1:0] disp_sel = 2'd0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [1:0] mode;
  logic       tick;
  logic       blink;
  logic [7:0] disp;

  bin_clock_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .disp_sel (disp_sel),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .mode     (mode),
    .tick     (tick),
    .blink    (blink),
    .disp     (disp)
  );

  always #5 clk = ~clk;

  // Free-running count of rising edges, used to timestamp ticks.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_compared   = 0;
  int n_mismatched = 0;
  int last_evt     = 0;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  typedef struct {
    int cyc;
    int sec;
  } tick_exp_t;

  exp_t      sb_q[$];
  tick_exp_t tick_q[$];

  function automatic int readSig(int id);
    case (id)
      SIG_SEC:   return int'(sec);
      SIG_MIN:   return int'(min);
      SIG_HR:    return int'(hr);
      SIG_MODE:  return int'(mode);
      SIG_TICK:  return int'(tick);
      SIG_BLINK: return int'(blink);
      default:   return int'(disp);
    endcase
  endfunction

  task automatic checkOutput(string tag, int observed, int expected);
    n_compared++;
    if (observed != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic expectSig(string tag, int id, int val);
    exp_t e;
    e.tag = tag;
    e.sig = id;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e.tag, readSig(e.sig), e.val);
    end
  endtask

  task automatic pushTick(int at_cyc, int exp_sec);
    tick_exp_t t;
    t.cyc = at_cyc;
    t.sec = exp_sec;
    tick_q.push_back(t);
  endtask

  task automatic waitCycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 mode, 1 inc, 2 both. The accepted press lands 4 edges after
  // the raw level rises (2 sync flops + DB debounce samples).
  task automatic applyStimulus(int which, int hold, int after);
    last_evt = cyc + 4;
    if (which != 1) btn_mode = 1'b1;
    if (which != 0) btn_inc  = 1'b1;
    waitCycles(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    waitCycles(after);
  endtask

  task automatic pressN(int which, int count);
    for (int i = 0; i < count; i++) applyStimulus(which, 6, 6);
  endtask

  // Every tick seen must match the next queued arrival; unqueued ticks fail.
  always @(negedge clk) begin
    tick_exp_t t;
    if (rst_n && tick) begin
      if (tick_q.size() == 0) begin
        checkOutput("tick_unexpected", int'(tick), 0);
      end else begin
        t = tick_q.pop_front();
        checkOutput("tick_cycle", cyc, t.cyc);
        checkOutput("tick_sec", int'(sec), t.sec);
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int k;

    // Reset state
    waitCycles(2);
    expectSig("rst_sec", SIG_SEC, 0);
    expectSig("rst_min", SIG_MIN, 0);
    expectSig("rst_hr", SIG_HR, 0);
    expectSig("rst_mode", SIG_MODE, 0);
    expectSig("rst_tick", SIG_TICK, 0);
    expectSig("rst_blink", SIG_BLINK, 1);
    expectSig("rst_disp", SIG_DISP, 0);
    drainScoreboard();

    // Free run: 60 ticks, 4 cycles apart
    rst_n = 1'b1;
    ena   = 1'b1;
    c0    = cyc;
    for (int i = 1; i <= 60; i++) pushTick(c0 + 4 * i, i % 60);
    waitCycles(240);
    expectSig("run_sec", SIG_SEC, 0);
    expectSig("run_min", SIG_MIN, 1);
    expectSig("run_hr", SIG_HR, 0);
    expectSig("run_disp_prev_sec", SIG_DISP, 59);
    drainScoreboard();

    // Enable low freezes the time
    ena = 1'b0;
    waitCycles(10);
    expectSig("frozen_sec", SIG_SEC, 0);
    expectSig("frozen_min", SIG_MIN, 1);
    drainScoreboard();

    ena = 1'b1;
    c0  = cyc;
    for (int i = 1; i <= 5; i++) pushTick(c0 + 4 * i, i);
    waitCycles(20);
    expectSig("resume_sec", SIG_SEC, 5);
    drainScoreboard();

    // Asynchronous reset mid-count, checked before the next clock edge
    waitCycles(2);
    rst_n = 1'b0;
    #1;
    expectSig("async_rst_sec", SIG_SEC, 0);
    expectSig("async_rst_min", SIG_MIN, 0);
    expectSig("async_rst_blink", SIG_BLINK, 1);
    expectSig("async_rst_disp", SIG_DISP, 0);
    drainScoreboard();

    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b0;

    // Inc press in RUN is ignored
    applyStimulus(1, 6, 6);
    expectSig("run_inc_hr", SIG_HR, 0);
    expectSig("run_inc_mode", SIG_MODE, 0);
    drainScoreboard();

    // Enter SET_H and follow the blink pattern from the mode event
    applyStimulus(0, 6, 6);
    expectSig("set_h_mode", SIG_MODE, 1);
    drainScoreboard();
    for (int i = 0; i < 8; i++) begin
      k = cyc - last_evt;
      checkOutput("blink_set_h", int'(blink), ((k / 2) % 2 == 0) ? 1 : 0);
      waitCycles(1);
    end

    pressN(1, 3);
    expectSig("hr_after_3", SIG_HR, 3);
    drainScoreboard();
    disp_sel = 2'd2;
    waitCycles(1);
    expectSig("disp_hr", SIG_DISP, 3);
    drainScoreboard();

    // Debounce: a one-cycle glitch is rejected, a clean press counts once
    applyStimulus(1, 1, 8);
    expectSig("glitch_hr", SIG_HR, 3);
    drainScoreboard();
    applyStimulus(1, 6, 6);
    expectSig("clean_hr", SIG_HR, 4);
    drainScoreboard();

    pressN(1, 19);
    expectSig("hr_23", SIG_HR, 23);
    expectSig("hr_23_min", SIG_MIN, 0);
    drainScoreboard();
    applyStimulus(1, 6, 6);
    expectSig("hr_wrap", SIG_HR, 0);
    expectSig("hr_wrap_min", SIG_MIN, 0);
    expectSig("hr_wrap_disp", SIG_DISP, 0);
    drainScoreboard();
    pressN(1, 23);
    expectSig("hr_set_23", SIG_HR, 23);
    drainScoreboard();

    // Simultaneous presses: mode wins, inc is dropped
    applyStimulus(2, 6, 6);
    expectSig("both_mode", SIG_MODE, 2);
    expectSig("both_hr", SIG_HR, 23);
    drainScoreboard();

    pressN(1, 59);
    expectSig("min_59", SIG_MIN, 59);
    expectSig("min_59_hr", SIG_HR, 23);
    drainScoreboard();
    applyStimulus(0, 6, 6);
    expectSig("set_s_mode", SIG_MODE, 3);
    drainScoreboard();
    pressN(1, 59);
    expectSig("sec_59", SIG_SEC, 59);
    expectSig("sec_59_min", SIG_MIN, 59);
    drainScoreboard();

    // Return to RUN at 23:59:59; first tick 4 cycles after the mode event
    ena = 1'b1;
    c0  = cyc;
    pushTick(c0 + 8, 0);
    applyStimulus(0, 6, 1);
    expectSig("pre_roll_mode", SIG_MODE, 0);
    expectSig("pre_roll_hr", SIG_HR, 23);
    expectSig("pre_roll_min", SIG_MIN, 59);
    expectSig("pre_roll_sec", SIG_SEC, 59);
    expectSig("pre_roll_blink", SIG_BLINK, 1);
    drainScoreboard();
    waitCycles(1);
    expectSig("roll_hr", SIG_HR, 0);
    expectSig("roll_min", SIG_MIN, 0);
    expectSig("roll_sec", SIG_SEC, 0);
    expectSig("roll_blink", SIG_BLINK, 1);
    drainScoreboard();

    ena      = 1'b0;
    disp_sel = 2'd3;
    waitCycles(1);
    expectSig("disp_status_tick", SIG_DISP, 8'h30);
    drainScoreboard();
    waitCycles(1);
    expectSig("disp_status_idle", SIG_DISP, 8'h20);
    expectSig("idle_tick", SIG_TICK, 0);
    drainScoreboard();

    waitCycles(4);
    checkOutput("tick_queue_drained", tick_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bin_clock_ctrl.md
Name: bin_clock_ctrl

Overview:
Timekeeping controller for the binary-clock design. It divides the system clock to a 1 Hz tick and maintains hours, minutes and seconds counters. A two-button set-mode state machine adjusts the time. One multiplexed 8-bit display word feeds the top-level uo_out pins.

Parameters:
DIV, 10000000, clock cycles per second tick (>=2, even)
DB_CYCLES, 1024, consecutive stable synchronized samples required to accept a button level change (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
ena  in  1  count enable; 0 freezes prescaler (buttons still processed)
btn_mode  in  1  raw mode button, async, active-high
btn_inc  in  1  raw increment button, async, active-high
disp_sel  in  2  display field select
sec  out  6  seconds 0..59
min  out  6  minutes 0..59
hr  out  5  hours 0..23
mode  out  2  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
tick  out  1  one-cycle pulse per second, asserted in the cycle the time registers update
blink  out  1  field-blink flag for the display
disp  out  8  registered display word

Behaviour:
- Reset (rst_n low, async) forces these values:
  - sec, min, hr = 0; mode = RUN; tick = 0; blink = 1; disp = 0.
  - Prescaler, blink counter and debounce counters = 0.
  - Synchronizer flops and accepted button levels = 0.
- Reset asserted mid-operation clears all state immediately. The first count starts DIV cycles after release.
- Button path, per button:
  - 2-flop synchronizer feeds a debounce counter.
  - The counter increments while the synchronized level differs from the accepted level, and clears when they match.
  - At DB_CYCLES the accepted level takes the new value and the counter clears.
  - A press event is a 0->1 transition of the accepted level, one cycle wide.
- Prescaler runs only when mode==RUN and ena==1:
  - It counts 0..DIV-1; at DIV-1 it wraps to 0 and the time increments.
  - tick is registered high for exactly that cycle.
- Time increment on tick:
  - sec+1. At 59, sec wraps to 0 and carries into min.
  - min 59 wraps to 0 and carries into hr.
  - hr 23 wraps to 0. So 23:59:59 becomes 00:00:00.
- FSM:
  - A mode press steps RUN->SET_H->SET_M->SET_S->RUN.
  - Entering SET_H clears the prescaler, which stays 0 in all SET states. tick stays 0 outside RUN.
  - The return to RUN resumes counting from prescaler 0, so the first tick comes DIV cycles later.
- Increment press in a SET state adds 1 to the selected field modulo its limit (hr mod 24, min/sec mod 60), with no carry. Increment press in RUN is ignored.
- Simultaneous mode and inc presses in one cycle: mode wins and inc is discarded.
- Blink:
  - In RUN, blink = 1 and the blink counter is held at 0.
  - Entering any SET state forces blink = 1 and clears the blink counter.
  - In SET states, blink toggles whenever the counter reaches DIV/2-1, then the counter wraps.
- disp is registered, with 1-cycle latency from disp_sel and the field values:
  - disp_sel 0: {2'b0, sec}
  - disp_sel 1: {2'b0, min}
  - disp_sel 2: {3'b0, hr}
  - disp_sel 3: {mode, blink, tick, 4'b0}
- All outputs other than disp are direct register outputs. No combinational path from inputs to outputs.

Test Plan:
1. Reset with DIV=4, DB_CYCLES=2 -> sec/min/hr=0, mode=0, blink=1, tick=0, disp=0. Assert rst_n low mid-count at sec=5 -> all cleared the same cycle, without waiting for a clk edge.
2. ena=1, RUN, 240 cycles after reset release -> 60 ticks, each 1 cycle wide and 4 cycles apart. Final min=1, sec=0. With ena=0 for 10 cycles, sec does not advance and tick stays 0.
3. Set 23:59:59 via SET states:
   - 23 inc presses in SET_H; 59 in SET_M; 59 in SET_S.
   - Return to RUN; first tick exactly 4 cycles later.
   - Required: hr=0, min=0, sec=0.
4. Set-mode edit: mode press -> mode=1; 3 inc presses -> hr=3. With hr=23, one inc -> hr=0 and min unchanged. disp_sel=2 -> disp=8'd3 one cycle after selection.
5. Debounce with DB_CYCLES=2: 1-cycle glitch on btn_inc in SET_H -> hr unchanged. Clean press held 6 cycles -> hr+1 exactly once.
6. In SET_H, pulse btn_mode and btn_inc so both press events land in the same cycle -> mode=2, hr unchanged. blink toggles every 2 cycles in SET states and reads 1 in RUN.
